instruction_fetch_queue: RTL

- Parametrised successor to the single-register fetch stage: a DEPTH-entry first-word-fall-through queue of {PC, instruction} pairs between the PC generator/instruction memory and decode.
- Adds a valid/ready handshake, back-pressure to fetch, occupancy reporting and a synchronous reset, on top of the existing stall/clear semantics.
- Decode stalls drain nothing. Branch or jump clears flush every queued entry in one cycle.

---
 rtl/instruction_fetch_queue.sv | 77 +++++++
 1 files changed

// File: rtl/instruction_fetch_queue.sv
// First-word-fall-through queue of {PC, instruction} pairs between fetch and decode.
// Supports decode stall, one-cycle flush on branch/jump clear, and synchronous reset.
module instruction_fetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CLEAR_INSTRUCTION_FETCH_STAGE,
    input  logic                     STALL_INSTRUCTION_FETCH_STAGE,
    input  logic [ADDRESS_WIDTH-1:0] PC_IN,
    input  logic [DATA_WIDTH-1:0]    INSTRUCTION_IN,
    input  logic                     PC_VALID_IN,
    output logic                     READY_OUT,
    output logic [ADDRESS_WIDTH-1:0] PC_OUT,
    output logic [DATA_WIDTH-1:0]    INSTRUCTION_OUT,
    output logic                     PC_VALID_OUT,
    output logic [COUNT_WIDTH-1:0]   COUNT_OUT
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
    logic [PTR_WIDTH-1:0]     rd_ptr;
    logic [PTR_WIDTH-1:0]     wr_ptr;
    logic [COUNT_WIDTH-1:0]   count;
    logic                     push;
    logic                     pop;

    // Handshake: a transfer happens on an edge where the sender's valid and the
    // receiver's ready are both high. Upstream: PC_VALID_IN / READY_OUT, and a
    // dropped entry must be held by upstream. Downstream: PC_VALID_OUT / !STALL.
    // READY_OUT depends on the registered count only, so a full queue refuses a
    // push even when it is popping in the same cycle.
    assign READY_OUT    = (count != FULL_COUNT);
    assign PC_VALID_OUT = (count != '0);
    assign COUNT_OUT    = count;

    assign push = PC_VALID_IN && READY_OUT;
    assign pop  = PC_VALID_OUT && !STALL_INSTRUCTION_FETCH_STAGE;

    // Empty queue presents zeros so decode never sees stale storage.
    assign PC_OUT          = PC_VALID_OUT ? pc_mem[rd_ptr]    : '0;
    assign INSTRUCTION_OUT = PC_VALID_OUT ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]    <= PC_IN;
            instr_mem[wr_ptr] <= INSTRUCTION_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || CLEAR_INSTRUCTION_FETCH_STAGE) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
